uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters, such as a command responder, a debug logger and a status reporter. It sequences the transmitter's start/busy handshake one byte at a time. It holds the grant for a whole packet, ended by a `last` flag, unless a burst or idle-gap limit forces rotation. It sits between the requesters and the UART TX datapath that pairs with uart_rx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced release (1..255)
GAP_TIMEOUT, 1024, cycles a granted requester may leave req_valid low mid-packet before release
ACK_TIMEOUT, 8, cycles allowed for tx_busy to rise after tx_start

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  byte for requester i at [8i+7:8i]
req_last  input  NUM_REQ  byte presented is the last of its packet
req_ready  output  NUM_REQ  one-cycle pulse: byte consumed
tx_data  output  8  byte to UART transmitter
tx_start  output  1  one-cycle start pulse to transmitter
tx_busy  input  1  transmitter busy (high for the whole frame)
grant_valid  output  1  a requester currently owns the transmitter
grant_id  output  3  index of owning requester
ack_err  output  1  one-cycle pulse: tx_busy did not rise within ACK_TIMEOUT

Behaviour:
- Reset is synchronous on rst, in any state: all outputs 0, state IDLE, rr_ptr=NUM_REQ-1, counters 0. A reset mid-frame abandons the byte; no req_ready is issued for it.
- All outputs are registered. The requester holds valid, data and last stable until it sees req_ready.
- States: IDLE, GRANT, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr+1 upward, modulo NUM_REQ.
  - Next cycle: grant_id is the pick, grant_valid=1, burst_cnt=0, gap_cnt=0, state GRANT.
  - If no req_valid is set, stay in IDLE.
- GRANT (g = grant_id):
  - If req_valid[g] and !tx_busy: in the next cycle tx_start=1, tx_data=req_data[g], req_ready[g]=1, and last_q=req_last[g] is latched. burst_cnt+1, gap_cnt=0, ack_cnt=0, state WAIT_ACK.
  - If req_valid[g] is low: gap_cnt+1. When gap_cnt reaches GAP_TIMEOUT-1, release.
  - If req_valid[g] is high but tx_busy is high: wait; gap_cnt holds.
- WAIT_ACK:
  - If tx_busy=1, go to WAIT_DONE.
  - Else ack_cnt+1. When ack_cnt reaches ACK_TIMEOUT-1: ack_err pulse, the byte is treated as sent, and the state evaluates the release condition as WAIT_DONE would.
- WAIT_DONE:
  - Stay while tx_busy=1.
  - On tx_busy=0: if last_q or burst_cnt==MAX_BURST, release; else go to GRANT.
- Release (one cycle): rr_ptr=g, grant_valid=0, state IDLE. Arbitration resumes the cycle after, so there is at least one idle cycle between grants. The released requester has lowest priority next round.
- Simultaneous requests: only the round-robin winner is granted; others keep waiting with req_ready low.
- Requests from non-granted requesters never affect the current grant. A new request arriving at the granted index during release is served in a later round.
- Throughput: at most one byte per transmitter frame plus 3 cycles.
- req_ready is only ever high on index grant_id and always coincides with tx_start.
- tx_start is never asserted while tx_busy=1.
- burst_cnt is 8 bits and saturates at MAX_BURST. gap_cnt and ack_cnt use $clog2 widths and cannot wrap.

Test Plan:
1. Single packet: requester 2 sends 0x41, 0x42, 0x43(last), with a tx_busy model of 20 cycles per frame. Expect 3 tx_start pulses with tx_data 0x41/0x42/0x43 in order, three req_ready[2] pulses, then grant_valid=0 and rr_ptr=2.
2. Round robin: all 4 requesters hold single-byte packets (last=1) with data 0x10+i, after reset. Expect grant order 0,1,2,3 then 0. No byte appears out of grant.
3. Burst limit: MAX_BURST=4, requester 1 streams 10 bytes with no last, requester 3 is also pending. Expect 4 bytes from 1, then 3's packet, then the remainder of 1.
4. Gap timeout: GAP_TIMEOUT=16, requester 0 sends 1 non-last byte then drops valid. Expect release exactly 16 cycles after entering GRANT; requester 1 (pending) is granted next.
5. Ack timeout: tx_busy is held at 0 after tx_start, ACK_TIMEOUT=8. Expect an ack_err pulse 8 cycles after tx_start, and no hang; the next byte proceeds.
6. Reset mid-frame: assert rst during WAIT_DONE. Expect all outputs 0 next cycle, state IDLE, and the arbiter starts from requester 0 after rst drops.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and UART transmitter handshake shared by the arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic                 ack_err;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_valid, grant_id, ack_err
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_valid, grant_id, ack_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART transmitter; grant held per packet, one byte per frame.
// All outputs registered; a byte is taken only when its owner is valid and the transmitter idle.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 1024,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK, WAIT_DONE} state_t;

    state_t             state, state_d;
    logic [2:0]         rr_ptr, rr_ptr_d;
    logic [2:0]         grant_id, grant_id_d;
    logic               grant_valid, grant_valid_d;
    logic               tx_start, tx_start_d;
    logic [7:0]         tx_data, tx_data_d;
    logic               ack_err, ack_err_d;
    logic [NUM_REQ-1:0] req_ready, req_ready_d;
    logic               last_q, last_d;
    logic [7:0]         burst_cnt, burst_d;
    logic [GW-1:0]      gap_cnt, gap_d;
    logic [AW-1:0]      ack_cnt, ack_d;

    logic               sel_valid, sel_last;
    logic [7:0]         sel_data;
    logic               pick_found;
    logic [2:0]         pick_id;
    logic               pkt_end;
    logic               release_now;

    // Round-robin search starting just above the last released owner.
    always_comb begin
        int tgt;
        tgt        = 0;
        pick_found = 1'b0;
        pick_id    = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            tgt = int'(rr_ptr) + k;
            if (tgt >= NUM_REQ) tgt = tgt - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_found && j == tgt && bus.req_valid[j]) begin
                    pick_found = 1'b1;
                    pick_id    = 3'(j);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == grant_id) begin
                sel_valid = bus.req_valid[j];
                sel_last  = bus.req_last[j];
                sel_data  = bus.req_data[8*j +: 8];
            end
        end
    end

    assign pkt_end = last_q || (burst_cnt == 8'(MAX_BURST));

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data;
        ack_err_d     = 1'b0;
        req_ready_d   = '0;
        last_d        = last_q;
        burst_d       = burst_cnt;
        gap_d         = gap_cnt;
        ack_d         = ack_cnt;
        release_now   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    burst_d       = 8'd0;
                    gap_d         = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (sel_valid && !bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = sel_data;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        req_ready_d[j] = (3'(j) == grant_id);
                    end
                    last_d  = sel_last;
                    burst_d = (burst_cnt == 8'(MAX_BURST)) ? burst_cnt : burst_cnt + 8'd1;
                    gap_d   = '0;
                    ack_d   = '0;
                    state_d = WAIT_ACK;
                end else if (!sel_valid) begin
                    if (gap_cnt == GW'(GAP_TIMEOUT - 1)) release_now = 1'b1;
                    else                                 gap_d = gap_cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never answered: count the byte as sent and move on.
                    ack_err_d = 1'b1;
                    if (pkt_end) release_now = 1'b1;
                    else         state_d = GRANT;
                end else begin
                    ack_d = ack_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (pkt_end) release_now = 1'b1;
                    else         state_d = GRANT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_now) begin
            rr_ptr_d      = grant_id;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 3'(NUM_REQ - 1);
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            ack_err     <= 1'b0;
            req_ready   <= '0;
            last_q      <= 1'b0;
            burst_cnt   <= 8'd0;
            gap_cnt     <= '0;
            ack_cnt     <= '0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            ack_err     <= ack_err_d;
            req_ready   <= req_ready_d;
            last_q      <= last_d;
            burst_cnt   <= burst_d;
            gap_cnt     <= gap_d;
            ack_cnt     <= ack_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.tx_data     = tx_data;
    assign bus.tx_start    = tx_start;
    assign bus.grant_valid = grant_valid;
    assign bus.grant_id    = grant_id;
    assign bus.ack_err     = ack_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues and a transmitter model drive the arbiter, a monitor checks bytes.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int GT    = 16;
    localparam int AT    = 8;
    localparam int FRAME = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .MAX_BURST(MB), .GAP_TIMEOUT(GT), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int start_cyc = 0;
    int ack_seen = 0;
    int rdy_cnt [NR];
    bit tx_en = 1'b1;

    logic [8:0]  rq [NR][$];
    logic [10:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_q.push_back({3'(r), d});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            rdy_cnt[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        clear_stim();
        cyc_wait(1);
        check(name, {bus.tx_start, bus.ack_err, bus.grant_valid, bus.grant_id, bus.req_ready, bus.tx_data}, 32'd0);
        cyc_wait(1);
        rst = 1'b0;
        cyc_wait(1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(exp_q.size() == 0 && all_empty() && !bus.grant_valid && !bus.tx_busy)) begin
            cyc_wait(1);
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
        cyc_wait(2);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!bus.tx_start && n < 300) begin
            cyc_wait(1);
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    // Requesters: present the head of each queue, retire it on req_ready.
    initial begin
        logic [NR-1:0]   v, l;
        logic [8*NR-1:0] d;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    v[i]       = 1'b1;
                    l[i]       = rq[i][0][8];
                    d[8*i +: 8] = rq[i][0][7:0];
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Transmitter: busy for FRAME cycles after each start, unless disabled.
    initial begin
        int bcnt;
        bcnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.tx_busy = 1'b0;
                bcnt = 0;
            end else if (bus.tx_busy) begin
                bcnt--;
                if (bcnt == 0) begin
                    bus.tx_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (bus.tx_start && tx_en) begin
                bus.tx_busy = 1'b1;
                bcnt = FRAME;
            end
        end
    end

    // Monitor: every started byte must be the next expected one from the owning requester.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got id %0d data 0x%0h, required no byte", bus.grant_id, bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_grant", {bus.grant_valid, bus.grant_id, bus.tx_data}, {1'b1, e});
                    check("ready_onehot", 32'(bus.req_ready), 32'(NR'(1) << e[10:8]));
                end
            end else if (bus.req_ready != '0) begin
                check("stray_ready", 32'(bus.req_ready), 32'd0);
            end
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
            if (bus.ack_err) begin
                ack_seen++;
                check("ack_err_delay", 32'(cyc - start_cyc), 32'(AT));
            end
        end
    end

    initial begin
        int n;
        do_reset("reset_outputs");

        // Single packet from requester 2, then rr_ptr=2 makes 3 win over 1.
        send(2, 8'h41, 1'b0); send(2, 8'h42, 1'b0); send(2, 8'h43, 1'b1);
        expect_byte(2, 8'h41); expect_byte(2, 8'h42); expect_byte(2, 8'h43);
        drain("single_packet_done");
        check("single_packet_readies", 32'(rdy_cnt[2]), 32'd3);
        send(1, 8'h51, 1'b1); send(3, 8'h53, 1'b1);
        expect_byte(3, 8'h53); expect_byte(1, 8'h51);
        drain("rr_after_release_done");

        // Round robin across all four, requester 0 queues a second packet.
        do_reset("reset_rr");
        for (int i = 0; i < NR; i++) send(i, 8'(8'h10 + i), 1'b1);
        send(0, 8'h20, 1'b1);
        for (int i = 0; i < NR; i++) expect_byte(i, 8'(8'h10 + i));
        expect_byte(0, 8'h20);
        drain("round_robin_done");

        // Burst limit of 4 forces rotation to requester 3.
        do_reset("reset_burst");
        for (int k = 0; k < 10; k++) send(1, 8'(8'hA0 + k), 1'b0);
        send(3, 8'h30, 1'b0); send(3, 8'h31, 1'b1);
        for (int k = 0; k < 4; k++) expect_byte(1, 8'(8'hA0 + k));
        expect_byte(3, 8'h30); expect_byte(3, 8'h31);
        for (int k = 4; k < 10; k++) expect_byte(1, 8'(8'hA0 + k));
        drain("burst_limit_done");

        // Gap timeout: 16 GRANT cycles after the frame ends, then release.
        do_reset("reset_gap");
        send(0, 8'h01, 1'b0); send(1, 8'h11, 1'b1);
        expect_byte(0, 8'h01); expect_byte(1, 8'h11);
        wait_start("gap_first_start");
        n = 0;
        while (bus.grant_valid && n < 500) begin
            cyc_wait(1);
            n++;
        end
        check("gap_release_cycles", 32'(cyc - fall_cyc), 32'd17);
        drain("gap_done");
        check("no_ack_err_yet", 32'(ack_seen), 32'd0);

        // Ack timeout: transmitter never goes busy.
        do_reset("reset_ack");
        tx_en = 1'b0;
        send(0, 8'h55, 1'b0); send(0, 8'h56, 1'b1);
        expect_byte(0, 8'h55); expect_byte(0, 8'h56);
        drain("ack_timeout_done");
        check("ack_err_count", 32'(ack_seen), 32'd2);
        tx_en = 1'b1;

        // Reset in the middle of a frame.
        do_reset("reset_mid_pre");
        send(2, 8'h77, 1'b0); send(2, 8'h78, 1'b1);
        expect_byte(2, 8'h77);
        wait_start("mid_start");
        cyc_wait(5);
        rst = 1'b1;
        check("mid_readies", 32'(rdy_cnt[2]), 32'd1);
        clear_stim();
        cyc_wait(1);
        check("reset_midframe_outputs",
              {bus.tx_start, bus.ack_err, bus.grant_valid, bus.grant_id, bus.req_ready, bus.tx_data}, 32'd0);
        cyc_wait(1);
        rst = 1'b0;
        cyc_wait(2);
        send(3, 8'h93, 1'b1); send(1, 8'h91, 1'b1);
        expect_byte(1, 8'h91); expect_byte(3, 8'h93);
        drain("after_reset_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
